// File: rtl/max7219_pkg.sv
// max7219_pkg: MAX7219 register map, word type and power-up
// table, shared by the row driver and its serializer.
package max7219_pkg;

  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DIGIT1    = 4'h2;
  localparam logic [3:0] REG_DIGIT2    = 4'h3;
  localparam logic [3:0] REG_DIGIT3    = 4'h4;
  localparam logic [3:0] REG_DIGIT4    = 4'h5;
  localparam logic [3:0] REG_DIGIT5    = 4'h6;
  localparam logic [3:0] REG_DIGIT6    = 4'h7;
  localparam logic [3:0] REG_DIGIT7    = 4'h8;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  localparam logic [2:0] INIT_LAST = 3'd4;

  typedef struct packed {
    logic [3:0] pad;
    logic [3:0] addr;
    logic [7:0] data;
  } word_t;

  typedef enum logic [1:0] {
    SEQ_RESET_INIT,
    SEQ_INIT_WORD,
    SEQ_SCAN_IDLE,
    SEQ_SCAN_WORD
  } seq_state_t;

  typedef enum logic [2:0] {
    SER_IDLE,
    SER_LOAD_WORD,
    SER_SHIFT_LO,
    SER_SHIFT_HI,
    SER_LATCH
  } ser_state_t;

  function automatic word_t mk_word(
    input logic [3:0] addr,
    input logic [7:0] data
  );
    word_t w;
    w.pad  = 4'h0;
    w.addr = addr;
    w.data = data;
    return w;
  endfunction

  function automatic word_t init_word(
    input logic [2:0] idx,
    input logic [3:0] intensity
  );
    word_t w;
    unique case (idx)
      3'd0:    w = mk_word(REG_SHUTDOWN, 8'h01);
      3'd1:    w = mk_word(REG_DECODE, 8'h00);
      3'd2:    w = mk_word(REG_SCANLIMIT, 8'h07);
      3'd3:    w = mk_word(REG_INTENSITY,
                           {4'h0, intensity});
      default: w = mk_word(REG_TEST, 8'h00);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/max7219_row_driver_if.sv
// Word handshake between the row sequencer and the
// 16-bit serializer.
interface max7219_row_driver_if;
  import max7219_pkg::*;

  logic  start;
  word_t word;
  logic  busy;
  logic  done;

  modport master (
    output start,
    output word,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  word,
    output busy,
    output done
  );

endinterface

// File: rtl/max7219_shift16.sv
// 16-bit MSB-first serializer for the MAX7219 DIN/CLK/LOAD
// link; the word is captured in the LOAD_WORD cycle.
module max7219_shift16
  import max7219_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  max7219_row_driver_if.slave        bus,
  output logic                       o_din,
  output logic                       o_sclk,
  output logic                       o_load
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  ser_state_t  r_state;
  ser_state_t  w_next;
  logic [7:0]  r_div;
  logic [3:0]  r_bit;
  logic [15:0] r_sh;
  logic        w_div_last;

  assign w_div_last = (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= SER_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SER_IDLE:
        if (bus.start) w_next = SER_LOAD_WORD;
      SER_LOAD_WORD:
        w_next = SER_SHIFT_LO;
      SER_SHIFT_LO:
        if (w_div_last) w_next = SER_SHIFT_HI;
      SER_SHIFT_HI:
        if (w_div_last)
          w_next = (r_bit == 4'd15) ? SER_LATCH
                                    : SER_SHIFT_LO;
      // a start in the last LATCH cycle chains words
      SER_LATCH:
        if (w_div_last)
          w_next = bus.start ? SER_LOAD_WORD : SER_IDLE;
      default:
        w_next = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_bit <= '0;
      r_sh  <= '0;
    end else begin
      if (w_div_last || r_state == SER_IDLE ||
          r_state == SER_LOAD_WORD)
        r_div <= '0;
      else
        r_div <= r_div + 8'd1;
      if (r_state == SER_LOAD_WORD) begin
        r_sh  <= bus.word;
        r_bit <= '0;
      end else if (r_state == SER_SHIFT_HI &&
                   w_div_last) begin
        r_sh  <= {r_sh[14:0], 1'b0};
        r_bit <= r_bit + 4'd1;
      end
    end
  end

  always_comb begin
    o_sclk   = 1'b0;
    o_load   = 1'b1;
    o_din    = 1'b0;
    bus.busy = 1'b1;
    bus.done = 1'b0;
    unique case (r_state)
      SER_IDLE:
        bus.busy = 1'b0;
      SER_LOAD_WORD: begin
        o_load = 1'b0;
        o_din  = bus.word[15];
      end
      SER_SHIFT_LO: begin
        o_load = 1'b0;
        o_din  = r_sh[15];
      end
      SER_SHIFT_HI: begin
        o_load = 1'b0;
        o_sclk = 1'b1;
        o_din  = r_sh[15];
      end
      SER_LATCH: begin
        bus.done = w_div_last;
        bus.busy = !w_div_last;
      end
      default:
        bus.busy = 1'b0;
    endcase
  end

endmodule

// File: rtl/max7219_row_driver.sv
// MAX7219 row driver: power-up register sequence, then a
// continuous scan of rows 0..7 from the row multiplexer.
module max7219_row_driver
  import max7219_pkg::*;
#(
  parameter int         CLK_DIV   = 4,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] max_in,
  output logic [2:0] act_add,
  output logic       max_din,
  output logic       max_clk,
  output logic       max_load,
  output logic       init_done,
  output logic       frame_done
);

  max7219_row_driver_if w_bus ();

  seq_state_t r_state;
  seq_state_t w_next;
  logic [2:0] r_idx;
  logic [2:0] r_row;
  logic       r_init_done;
  logic       r_frame_done;
  logic       w_last_init;

  assign w_last_init = (r_idx == INIT_LAST);

  max7219_shift16 #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk    (clk),
    .reset  (reset),
    .bus    (w_bus),
    .o_din  (max_din),
    .o_sclk (max_clk),
    .o_load (max_load)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= SEQ_RESET_INIT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SEQ_RESET_INIT:
        if (!w_bus.busy) w_next = SEQ_INIT_WORD;
      SEQ_INIT_WORD:
        if (w_bus.done && w_last_init)
          w_next = enable ? SEQ_SCAN_WORD
                          : SEQ_SCAN_IDLE;
      SEQ_SCAN_IDLE:
        if (enable && !w_bus.busy)
          w_next = SEQ_SCAN_WORD;
      SEQ_SCAN_WORD:
        if (w_bus.done && !enable)
          w_next = SEQ_SCAN_IDLE;
      default:
        w_next = SEQ_RESET_INIT;
    endcase
  end

  // word is read by the serializer in LOAD_WORD, after
  // r_idx / r_row have already advanced
  always_comb begin
    w_bus.start = 1'b0;
    w_bus.word  = mk_word(REG_DIGIT0 + {1'b0, r_row},
                          max_in);
    unique case (r_state)
      SEQ_RESET_INIT: begin
        w_bus.start = !w_bus.busy;
        w_bus.word  = init_word(r_idx, INTENSITY);
      end
      SEQ_INIT_WORD: begin
        w_bus.start = w_bus.done &&
                      (!w_last_init || enable);
        w_bus.word  = init_word(r_idx, INTENSITY);
      end
      SEQ_SCAN_IDLE:
        w_bus.start = enable && !w_bus.busy;
      SEQ_SCAN_WORD:
        w_bus.start = w_bus.done && enable;
      default:
        w_bus.start = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= '0;
      r_row        <= '0;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_state == SEQ_INIT_WORD && w_bus.done) begin
        if (w_last_init) r_init_done <= 1'b1;
        else             r_idx <= r_idx + 3'd1;
      end
      if (r_state == SEQ_SCAN_WORD && w_bus.done) begin
        r_row        <= r_row + 3'd1;
        r_frame_done <= (r_row == 3'd7);
      end
    end
  end

  assign act_add    = r_row;
  assign init_done  = r_init_done;
  assign frame_done = r_frame_done;

endmodule
